// File: rtl/segment_transition_ctl_pkg.sv
// Shared constants and types for the read-segment transition controller.
package segment_transition_ctl_pkg;

    localparam logic [2:0] TRANSITION_MODE_IMMEDIATE = 3'd0;
    localparam logic [2:0] TRANSITION_MODE_SYNC_IDX  = 3'd1;
    localparam logic [2:0] TRANSITION_MODE_SYS_TIME  = 3'd2;
    localparam logic [2:0] TRANSITION_MODE_GPIO      = 3'd3;

    localparam int               REP_W_DEF    = 16;
    localparam logic [REP_W_DEF-1:0] REP_INFINITE = '1;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } seg_ctl_state_t;

    function automatic logic mode_valid(input logic [2:0] mode);
        return (mode <= TRANSITION_MODE_GPIO);
    endfunction

endpackage

// File: rtl/segment_transition_ctl.sv
// Holds a host segment-swap request until its trigger fires, swaps SEGMENT,
// and counts loop repetitions to raise STOP once the programmed repeats run out.
module segment_transition_ctl
    import segment_transition_ctl_pkg::*;
#(
    parameter int REP_W  = 16,
    parameter int TIME_W = 56,
    parameter int NGPIO  = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              UPDATE,
    input  logic              REQ_SEGMENT,
    input  logic [2:0]        REQ_MODE,
    input  logic [REP_W-1:0]  REQ_REP,
    input  logic [TIME_W-1:0] REQ_TIME,
    input  logic [1:0]        REQ_GPIO,
    input  logic [TIME_W-1:0] SYS_TIME,
    input  logic [NGPIO-1:0]  GPIO_IN,
    input  logic              LOOP_END,
    output logic              SEGMENT,
    output logic              STOP,
    output logic              BUSY,
    output logic              SWAPPED,
    output logic              REQ_ERR
);

    localparam logic [REP_W-1:0] REP_INF = '1;

    seg_ctl_state_t    state_q, state_d;
    logic              seg_q, seg_d;
    logic              stop_q, stop_d;
    logic              swapped_q, swapped_d;
    logic              req_err_q, req_err_d;
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic              pend_seg_q, pend_seg_d;
    logic [2:0]        pend_mode_q, pend_mode_d;
    logic [REP_W-1:0]  pend_rep_q, pend_rep_d;
    logic [TIME_W-1:0] pend_time_q, pend_time_d;
    logic [1:0]        pend_gpio_q, pend_gpio_d;
    logic [NGPIO-1:0]  gpio_q, gpio_d;
    logic [NGPIO-1:0]  gpio_prev_q, gpio_prev_d;
    logic              trig_s;
    logic              upd_ok_s;

    // Trigger select: only the latched request is evaluated, and only while pending.
    always_comb begin
        trig_s = 1'b0;
        if (state_q == PEND) begin
            case (pend_mode_q)
                TRANSITION_MODE_IMMEDIATE: trig_s = 1'b1;
                TRANSITION_MODE_SYNC_IDX:  trig_s = LOOP_END | stop_q;
                TRANSITION_MODE_SYS_TIME:  trig_s = (SYS_TIME >= pend_time_q);
                TRANSITION_MODE_GPIO:      trig_s = gpio_q[pend_gpio_q] & ~gpio_prev_q[pend_gpio_q];
                default:                   trig_s = 1'b0;
            endcase
        end else begin
            trig_s = 1'b0;
        end
    end

    // Next-state: a swap takes priority over repeat counting in the same cycle.
    always_comb begin
        upd_ok_s    = UPDATE & mode_valid(REQ_MODE);
        state_d     = state_q;
        seg_d       = seg_q;
        stop_d      = stop_q;
        rep_cnt_d   = rep_cnt_q;
        pend_seg_d  = pend_seg_q;
        pend_mode_d = pend_mode_q;
        pend_rep_d  = pend_rep_q;
        pend_time_d = pend_time_q;
        pend_gpio_d = pend_gpio_q;
        swapped_d   = trig_s;
        req_err_d   = UPDATE & ~mode_valid(REQ_MODE);
        gpio_d      = GPIO_IN;
        gpio_prev_d = gpio_q;

        if (trig_s) begin
            seg_d     = pend_seg_q;
            rep_cnt_d = pend_rep_q;
            stop_d    = 1'b0;
        end else if (LOOP_END && !stop_q && (rep_cnt_q != REP_INF)) begin
            if (rep_cnt_q == '0) begin
                stop_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q - REP_W'(1);
            end
        end else begin
            rep_cnt_d = rep_cnt_q;
        end

        // A new valid request always wins, even over the swap completing now.
        if (upd_ok_s) begin
            state_d     = PEND;
            pend_seg_d  = REQ_SEGMENT;
            pend_mode_d = REQ_MODE;
            pend_rep_d  = REQ_REP;
            pend_time_d = REQ_TIME;
            pend_gpio_d = REQ_GPIO;
        end else if (trig_s) begin
            state_d = RUN;
        end else begin
            state_d = state_q;
        end
    end

    // All controller state, including the two-stage GPIO edge history.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= RUN;
            seg_q       <= 1'b0;
            stop_q      <= 1'b0;
            swapped_q   <= 1'b0;
            req_err_q   <= 1'b0;
            rep_cnt_q   <= REP_INF;
            pend_seg_q  <= 1'b0;
            pend_mode_q <= 3'd0;
            pend_rep_q  <= '0;
            pend_time_q <= '0;
            pend_gpio_q <= 2'd0;
            gpio_q      <= '0;
            gpio_prev_q <= '0;
        end else begin
            state_q     <= state_d;
            seg_q       <= seg_d;
            stop_q      <= stop_d;
            swapped_q   <= swapped_d;
            req_err_q   <= req_err_d;
            rep_cnt_q   <= rep_cnt_d;
            pend_seg_q  <= pend_seg_d;
            pend_mode_q <= pend_mode_d;
            pend_rep_q  <= pend_rep_d;
            pend_time_q <= pend_time_d;
            pend_gpio_q <= pend_gpio_d;
            gpio_q      <= gpio_d;
            gpio_prev_q <= gpio_prev_d;
        end
    end

    assign SEGMENT = seg_q;
    assign STOP    = stop_q;
    assign BUSY    = (state_q == PEND);
    assign SWAPPED = swapped_q;
    assign REQ_ERR = req_err_q;

endmodule

// File: tb/tb_segment_transition_ctl.sv
// Directed bench for segment_transition_ctl with a loop-budget reference model.
module tb_segment_transition_ctl;
    import segment_transition_ctl_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        UPDATE = 1'b0;
    logic        REQ_SEGMENT = 1'b0;
    logic [2:0]  REQ_MODE = 3'd0;
    logic [15:0] REQ_REP = 16'd0;
    logic [55:0] REQ_TIME = 56'd0;
    logic [1:0]  REQ_GPIO = 2'd0;
    logic [55:0] SYS_TIME = 56'd1000;
    logic [3:0]  GPIO_IN = 4'd0;
    logic        LOOP_END = 1'b0;
    logic        SEGMENT, STOP, BUSY, SWAPPED, REQ_ERR;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model state: expected outputs plus the pending request and loops left to play.
    bit          m_seg, m_stop, m_busy, m_swp, m_err;
    int          m_left;
    bit          p_seg;
    logic [2:0]  p_mode;
    logic [15:0] p_rep;
    logic [55:0] p_time;
    logic [1:0]  p_gpio;
    bit   [3:0]  g1, g2;
    logic [55:0] thr;

    segment_transition_ctl dut (
        .CLK(CLK), .RST_N(RST_N), .UPDATE(UPDATE), .REQ_SEGMENT(REQ_SEGMENT),
        .REQ_MODE(REQ_MODE), .REQ_REP(REQ_REP), .REQ_TIME(REQ_TIME), .REQ_GPIO(REQ_GPIO),
        .SYS_TIME(SYS_TIME), .GPIO_IN(GPIO_IN), .LOOP_END(LOOP_END),
        .SEGMENT(SEGMENT), .STOP(STOP), .BUSY(BUSY), .SWAPPED(SWAPPED), .REQ_ERR(REQ_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_seg = 1'b0; m_stop = 1'b0; m_busy = 1'b0; m_swp = 1'b0; m_err = 1'b0;
        m_left = -1;
        g1 = 4'd0; g2 = 4'd0;
    endtask

    // m_left counts loops still to play (-1 = endless); STOP when it reaches zero.
    task automatic model_step();
        bit trig;
        trig = 1'b0;
        if (m_busy) begin
            case (p_mode)
                3'd0:    trig = 1'b1;
                3'd1:    trig = LOOP_END || m_stop;
                3'd2:    trig = (SYS_TIME >= p_time);
                3'd3:    trig = g1[p_gpio] && !g2[p_gpio];
                default: trig = 1'b0;
            endcase
        end
        m_err = UPDATE && (REQ_MODE > 3'd3);
        m_swp = trig;
        if (trig) begin
            m_seg  = p_seg;
            m_stop = 1'b0;
            m_left = (p_rep == 16'hFFFF) ? -1 : int'(p_rep) + 1;
        end else if (LOOP_END && !m_stop && m_left > 0) begin
            m_left--;
            if (m_left == 0) m_stop = 1'b1;
        end
        if (UPDATE && REQ_MODE <= 3'd3) begin
            m_busy = 1'b1;
            p_seg = REQ_SEGMENT; p_mode = REQ_MODE; p_rep = REQ_REP;
            p_time = REQ_TIME; p_gpio = REQ_GPIO;
        end else if (trig) begin
            m_busy = 1'b0;
        end
        g2 = g1;
        g1 = GPIO_IN;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (cmp_en) begin
                chk("model_SEGMENT", SEGMENT, m_seg);
                chk("model_STOP", STOP, m_stop);
                chk("model_BUSY", BUSY, m_busy);
                chk("model_SWAPPED", SWAPPED, m_swp);
                chk("model_REQ_ERR", REQ_ERR, m_err);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge CLK);
            SYS_TIME = SYS_TIME + 56'd1;
        end
    endtask

    task automatic upd(input logic seg, input logic [2:0] mode, input logic [15:0] rep,
                       input logic [55:0] t, input logic [1:0] g);
        UPDATE = 1'b1; REQ_SEGMENT = seg; REQ_MODE = mode; REQ_REP = rep;
        REQ_TIME = t; REQ_GPIO = g;
        step(1);
        UPDATE = 1'b0;
    endtask

    task automatic le();
        LOOP_END = 1'b1;
        step(1);
        LOOP_END = 1'b0;
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        step(2);
        RST_N = 1'b1;
        cmp_en = 1'b1;
        chk("rst_seg", SEGMENT, 1'b0);
        chk("rst_stop", STOP, 1'b0);
        chk("rst_busy", BUSY, 1'b0);

        // Idle with loop-end pulses: endless repeat count, nothing happens.
        for (int i = 0; i < 10; i++) begin
            LOOP_END = (i % 2 == 0);
            step(1);
            chk("idle_swapped", SWAPPED, 1'b0);
        end
        LOOP_END = 1'b0;
        chk("idle_seg", SEGMENT, 1'b0);
        chk("idle_stop", STOP, 1'b0);

        // Immediate swap, rep=2 -> three loops then STOP.
        upd(1'b1, 3'd0, 16'd2, 56'd0, 2'd0);
        chk("imm_busy_t1", BUSY, 1'b1);
        chk("imm_seg_t1", SEGMENT, 1'b0);
        step(1);
        chk("imm_seg_t2", SEGMENT, 1'b1);
        chk("imm_swp_t2", SWAPPED, 1'b1);
        chk("imm_busy_t2", BUSY, 1'b0);
        le(); le();
        chk("rep_stop_after2", STOP, 1'b0);
        le();
        chk("rep_stop_after3", STOP, 1'b1);
        le();
        chk("rep_stop_after4", STOP, 1'b1);
        chk("rep_seg_after4", SEGMENT, 1'b1);

        // Sync-index request while stopped fires on the first pending cycle.
        upd(1'b0, 3'd1, REP_INFINITE, 56'd0, 2'd0);
        chk("syncstop_busy", BUSY, 1'b1);
        step(1);
        chk("syncstop_seg", SEGMENT, 1'b0);
        chk("syncstop_swp", SWAPPED, 1'b1);
        chk("syncstop_stop", STOP, 1'b0);

        // Sync-index waits for LOOP_END.
        upd(1'b1, 3'd1, REP_INFINITE, 56'd0, 2'd0);
        step(5);
        chk("sync_busy_wait", BUSY, 1'b1);
        chk("sync_seg_wait", SEGMENT, 1'b0);
        le();
        chk("sync_seg", SEGMENT, 1'b1);
        chk("sync_swp", SWAPPED, 1'b1);

        // LOOP_END consumed by the swap does not count: rep=1 needs two more.
        upd(1'b0, 3'd1, 16'd1, 56'd0, 2'd0);
        step(2);
        le();
        chk("swaple_seg", SEGMENT, 1'b0);
        chk("swaple_stop0", STOP, 1'b0);
        le();
        chk("swaple_stop1", STOP, 1'b0);
        le();
        chk("swaple_stop2", STOP, 1'b1);

        // UPDATE in the trigger cycle: old swap completes, new request pends.
        upd(1'b1, 3'd1, REP_INFINITE, 56'd0, 2'd0);
        upd(1'b0, 3'd0, REP_INFINITE, 56'd0, 2'd0);
        chk("coin_seg_old", SEGMENT, 1'b1);
        chk("coin_busy", BUSY, 1'b1);
        step(1);
        chk("coin_seg_new", SEGMENT, 1'b0);
        chk("coin_swp_new", SWAPPED, 1'b1);

        // System-time threshold.
        thr = SYS_TIME + 56'd100;
        upd(1'b1, 3'd2, REP_INFINITE, thr, 2'd0);
        for (int k = 0; k < 300 && SYS_TIME != thr; k++) step(1);
        chk("time_reached", SYS_TIME == thr, 1'b1);
        chk("time_seg_before", SEGMENT, 1'b0);
        chk("time_busy_before", BUSY, 1'b1);
        step(1);
        chk("time_seg_after", SEGMENT, 1'b1);
        chk("time_swp_after", SWAPPED, 1'b1);
        upd(1'b0, 3'd2, REP_INFINITE, SYS_TIME - 56'd5, 2'd0);
        chk("past_busy", BUSY, 1'b1);
        step(1);
        chk("past_seg", SEGMENT, 1'b0);
        chk("past_swp", SWAPPED, 1'b1);

        // GPIO trigger on index 2 only.
        upd(1'b1, 3'd3, REP_INFINITE, 56'd0, 2'd2);
        GPIO_IN = 4'b0010;
        step(2);
        GPIO_IN = 4'b0000;
        step(3);
        chk("gpio_wrong_seg", SEGMENT, 1'b0);
        chk("gpio_wrong_busy", BUSY, 1'b1);
        GPIO_IN = 4'b0100;
        step(1);
        chk("gpio_seg_t1", SEGMENT, 1'b0);
        step(1);
        chk("gpio_seg_t2", SEGMENT, 1'b1);
        chk("gpio_swp_t2", SWAPPED, 1'b1);
        GPIO_IN = 4'b0000;
        upd(1'b0, 3'd0, REP_INFINITE, 56'd0, 2'd0);
        step(1);

        // Later request replaces a pending GPIO request.
        upd(1'b1, 3'd3, REP_INFINITE, 56'd0, 2'd2);
        step(2);
        upd(1'b0, 3'd0, REP_INFINITE, 56'd0, 2'd0);
        step(1);
        chk("disc_swp_same", SWAPPED, 1'b1);
        GPIO_IN = 4'b0100;
        step(4);
        chk("disc_seg", SEGMENT, 1'b0);
        chk("disc_busy", BUSY, 1'b0);
        GPIO_IN = 4'b0000;

        // Invalid mode.
        upd(1'b1, 3'd5, 16'd0, 56'd0, 2'd0);
        chk("err_pulse", REQ_ERR, 1'b1);
        chk("err_busy", BUSY, 1'b0);
        step(1);
        chk("err_clear", REQ_ERR, 1'b0);
        chk("err_seg", SEGMENT, 1'b0);

        // Asynchronous reset while pending.
        upd(1'b1, 3'd0, REP_INFINITE, 56'd0, 2'd0);
        step(1);
        upd(1'b0, 3'd1, REP_INFINITE, 56'd0, 2'd0);
        chk("prerst_busy", BUSY, 1'b1);
        chk("prerst_seg", SEGMENT, 1'b1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_rst_busy", BUSY, 1'b0);
        chk("async_rst_seg", SEGMENT, 1'b0);
        step(2);
        RST_N = 1'b1;
        step(3);
        chk("postrst_seg", SEGMENT, 1'b0);
        chk("postrst_busy", BUSY, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
